mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-ported, fixed-latency unified memory between the multicycle core (instruction fetch and LW/SW) and the DMA/program-loader port. It serialises accesses, issues one memory command per grant, waits out the memory latency, and returns read data with a one-cycle completion pulse. The core holds its memory-phase state until it sees completion.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 36 +++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the core/DMA memory arbiter: FSM states, requester ids, latency limit.
package mem_arb_pkg;
  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    REQ_CORE,
    REQ_DMA
  } req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational winner, last-granted pointer updated on i_upd.
// On a tie the requester that was not granted last wins; the pointer resets to DMA.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_c_req,
  input  logic i_d_req,
  input  logic i_upd,
  output logic o_winner
);

  req_id_t r_last;
  req_id_t w_win;

  always_comb begin
    w_win = REQ_CORE;
    if (i_c_req && i_d_req) begin
      w_win = (r_last == REQ_CORE) ? REQ_DMA : REQ_CORE;
    end else if (i_d_req) begin
      w_win = REQ_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= REQ_DMA;
    end else if (i_upd) begin
      r_last <= w_win;
    end
  end

  assign o_winner = w_win;

endmodule

// File: rtl/mem_arbiter.sv
// Core/DMA arbiter for a single-ported fixed-latency memory; one access per MEM_LAT+3 cycles, done at req+MEM_LAT+2.
// Requesters hold req until done. Define MEM_ARBITER_CORE_PRIO_EN for fixed core priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t        r_state;
  state_t        w_next;
  req_id_t       r_id;
  req_id_t       w_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_c_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_take;
  logic          w_last_wait;
  logic          w_rd_cap;

  assign w_take      = (r_state == IDLE) && (c_req || d_req);
  assign w_last_wait = (r_state == WAIT) && (r_cnt == CW'(1));
  assign w_rd_cap    = w_last_wait && !r_we;

`ifdef MEM_ARBITER_CORE_PRIO_EN
  assign w_win = c_req ? REQ_CORE : REQ_DMA;
`else
  logic w_win_raw;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .i_c_req  (c_req),
    .i_d_req  (d_req),
    .i_upd    (w_take),
    .o_winner (w_win_raw)
  );

  assign w_win = req_id_t'(w_win_raw);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Requests are only sampled in IDLE; anything arriving later waits its turn.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (c_req || d_req) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt == CW'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    m_en   = 1'b0;
    m_we   = 1'b0;
    c_gnt  = 1'b0;
    d_gnt  = 1'b0;
    c_done = 1'b0;
    d_done = 1'b0;
    if (r_state == ISSUE) begin
      m_en = 1'b1;
      m_we = r_we;
    end
    if (r_state != IDLE) begin
      c_gnt = (r_id == REQ_CORE);
      d_gnt = (r_id == REQ_DMA);
    end
    if (r_state == DONE) begin
      c_done = (r_id == REQ_CORE);
      d_done = (r_id == REQ_DMA);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id      <= REQ_CORE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_take) begin
        r_id    <= w_win;
        r_we    <= (w_win == REQ_CORE) ? c_we    : d_we;
        r_addr  <= (w_win == REQ_CORE) ? c_addr  : d_addr;
        r_wdata <= (w_win == REQ_CORE) ? c_wdata : d_wdata;
      end
      if (r_state == ISSUE) begin
        r_cnt <= CW'(MEM_LAT);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_rd_cap) begin
        if (r_id == REQ_CORE) r_c_rdata <= m_rdata;
        else                  r_d_rdata <= m_rdata;
      end
    end
  end

  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign c_rdata = r_c_rdata;
  assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEM_LAT 2, 1 and 15 sharing one behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req [3];
  logic        d_req [3];
  logic        c_we, d_we;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_gnt [3], d_gnt [3], c_done [3], d_done [3];
  logic        m_en [3], m_we [3];
  logic [31:0] c_rdata [3], d_rdata [3];
  logic [31:0] m_addr [3], m_wdata [3], m_rdata [3];
  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [31:0] pipe [16];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_dut (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req[g]),
      .c_we    (c_we),
      .c_addr  (c_addr),
      .c_wdata (c_wdata),
      .c_gnt   (c_gnt[g]),
      .c_done  (c_done[g]),
      .c_rdata (c_rdata[g]),
      .d_req   (d_req[g]),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_gnt   (d_gnt[g]),
      .d_done  (d_done[g]),
      .d_rdata (d_rdata[g]),
      .m_en    (m_en[g]),
      .m_we    (m_we[g]),
      .m_addr  (m_addr[g]),
      .m_wdata (m_wdata[g]),
      .m_rdata (m_rdata[g])
    );

    // Read data is only meaningful exactly L cycles after the strobe.
    always @(posedge clk) begin
      pipe[0] <= m_en[g] ? mem[m_addr[g][7:2]] : 32'hxxxx_xxxx;
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata[g] = pipe[L-1];
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    mem[0] <= 32'h8C02_0004;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_en[k] && m_we[k]) mem[m_addr[k][7:2]] <= m_wdata[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({c_gnt[0], d_gnt[0], c_done[0], d_done[0], m_en[0], m_we[0]} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b exp 000000", {c_gnt[0], d_gnt[0], c_done[0], d_done[0], m_en[0], m_we[0]});
    end
    n_cmp++;
    if ({m_addr[0], m_wdata[0]} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mbus: got %h %h exp 0 0", m_addr[0], m_wdata[0]);
    end
    n_cmp++;
    if ({c_rdata[0], d_rdata[0]} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h %h exp 0 0", c_rdata[0], d_rdata[0]);
    end
  endtask

  task automatic test_core_read();
    c_we = 1'b0; c_addr = 32'h0; c_req[0] = 1'b1;
    tick();
    n_cmp++;
    if ({m_en[0], m_we[0], c_gnt[0], d_gnt[0]} !== 4'b1010) begin
      n_err++;
      $display("FAIL cr_issue: got en/we/cg/dg %b exp 1010", {m_en[0], m_we[0], c_gnt[0], d_gnt[0]});
    end
    n_cmp++;
    if (m_addr[0] !== 32'h0) begin
      n_err++;
      $display("FAIL cr_addr: got %h exp 0", m_addr[0]);
    end
    tick();
    tick();
    n_cmp++;
    if ({m_en[0], c_done[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL cr_wait: got en/done %b exp 00", {m_en[0], c_done[0]});
    end
    tick();
    n_cmp++;
    if (c_done[0] !== 1'b1) begin
      n_err++;
      $display("FAIL cr_done_t4: got %b exp 1", c_done[0]);
    end
    n_cmp++;
    if (c_rdata[0] !== 32'h8C02_0004 || d_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL cr_rdata: got c=%h d=%h exp c=8c020004 d=0", c_rdata[0], d_rdata[0]);
    end
    c_req[0] = 1'b0;
    tick();
    n_cmp++;
    if ({c_done[0], c_gnt[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL cr_release: got done/gnt %b exp 00", {c_done[0], c_gnt[0]});
    end
  endtask

  task automatic test_dma_write();
    d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_req[0] = 1'b1;
    tick();
    n_cmp++;
    if ({m_en[0], m_we[0], d_gnt[0], c_gnt[0]} !== 4'b1110) begin
      n_err++;
      $display("FAIL dw_issue: got en/we/dg/cg %b exp 1110", {m_en[0], m_we[0], d_gnt[0], c_gnt[0]});
    end
    n_cmp++;
    if (m_addr[0] !== 32'h40 || m_wdata[0] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL dw_payload: got %h %h exp 00000040 deadbeef", m_addr[0], m_wdata[0]);
    end
    tick();
    n_cmp++;
    if (m_en[0] !== 1'b0) begin
      n_err++;
      $display("FAIL dw_one_strobe: got m_en %b exp 0", m_en[0]);
    end
    tick();
    tick();
    n_cmp++;
    if ({d_done[0], c_done[0]} !== 2'b10) begin
      n_err++;
      $display("FAIL dw_done_t4: got d/c done %b exp 10", {d_done[0], c_done[0]});
    end
    n_cmp++;
    if (d_rdata[0] !== 32'h0 || c_rdata[0] !== 32'h8C02_0004) begin
      n_err++;
      $display("FAIL dw_rdata: got d=%h c=%h exp d=0 c=8c020004", d_rdata[0], c_rdata[0]);
    end
    d_req[0] = 1'b0; d_we = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic [3:0]  seq = 4'b0;
    logic [3:0]  exp_seq;
    logic [31:0] exp_d;
    int nd = 0, first = -1, last = 0, overlap = 0;
`ifdef MEM_ARBITER_CORE_PRIO_EN
    exp_seq = 4'b1111;
    exp_d   = 32'h0;
`else
    exp_seq = 4'b1010;
    exp_d   = 32'h8C02_0004;
`endif
    c_we = 1'b0; c_addr = 32'h40; d_we = 1'b0; d_addr = 32'h0;
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 40 && nd < 4; cyc++) begin
      tick();
      if (c_gnt[0] && d_gnt[0]) overlap++;
      if (c_done[0] || d_done[0]) begin
        seq = {seq[2:0], c_done[0]};
        if (nd == 0) first = cyc;
        last = cyc;
        nd++;
        if (nd == 4) begin
          c_req[0] = 1'b0; d_req[0] = 1'b0;
        end
      end
    end
    tick();
    n_cmp++;
    if (nd !== 4) begin
      n_err++;
      $display("FAIL alt_count: got %0d done pulses exp 4", nd);
    end
    n_cmp++;
    if (seq !== exp_seq) begin
      n_err++;
      $display("FAIL alt_order: got core-bits %b exp %b", seq, exp_seq);
    end
    n_cmp++;
    if (first !== 4 || last - first !== 15) begin
      n_err++;
      $display("FAIL alt_spacing: got first %0d span %0d exp 4 15", first, last - first);
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_err++;
      $display("FAIL alt_overlap: got %0d exp 0", overlap);
    end
    n_cmp++;
    if (c_rdata[0] !== 32'hDEAD_BEEF || d_rdata[0] !== exp_d) begin
      n_err++;
      $display("FAIL alt_rdata: got c=%h d=%h exp c=deadbeef d=%h", c_rdata[0], d_rdata[0], exp_d);
    end
  endtask

  task automatic test_lat();
    int got1 = 0, got15 = 0, overlap = 0;
    c_we = 1'b0; c_addr = 32'h0;
    c_req[1] = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (c_gnt[1] && d_gnt[1]) overlap++;
      if (c_done[1]) begin
        got1 = cyc;
        c_req[1] = 1'b0;
        break;
      end
    end
    tick();
    c_req[2] = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (c_gnt[2] && d_gnt[2]) overlap++;
      if (c_done[2]) begin
        got15 = cyc;
        c_req[2] = 1'b0;
        break;
      end
    end
    tick();
    n_cmp++;
    if (got1 !== 3) begin
      n_err++;
      $display("FAIL lat1_done: got cycle %0d exp 3", got1);
    end
    n_cmp++;
    if (got15 !== 17) begin
      n_err++;
      $display("FAIL lat15_done: got cycle %0d exp 17", got15);
    end
    n_cmp++;
    if (c_rdata[1] !== 32'h8C02_0004 || c_rdata[2] !== 32'h8C02_0004) begin
      n_err++;
      $display("FAIL lat_rdata: got %h %h exp 8c020004 8c020004", c_rdata[1], c_rdata[2]);
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_err++;
      $display("FAIL lat_overlap: got %0d exp 0", overlap);
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    c_we = 1'b0; c_addr = 32'h0; c_req[0] = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (c_gnt[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rm_in_wait: got c_gnt %b exp 1", c_gnt[0]);
    end
    reset = 1'b0; c_req[0] = 1'b0;
    tick();
    n_cmp++;
    if ({c_gnt[0], m_en[0], c_done[0]} !== 3'b000) begin
      n_err++;
      $display("FAIL rm_idle: got gnt/en/done %b exp 000", {c_gnt[0], m_en[0], c_done[0]});
    end
    n_cmp++;
    if (c_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL rm_rdata: got %h exp 0", c_rdata[0]);
    end
    reset = 1'b1;
    repeat (8) begin
      tick();
      if (c_done[0]) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL rm_no_done: got %0d pulses exp 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    int nd = 0, t1 = 0, t2 = 0;
    c_we = 1'b0; c_addr = 32'h40; c_req[0] = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      tick();
      if (c_done[0]) begin
        nd++;
        if (nd == 1) t1 = cyc;
        if (nd == 2) begin
          t2 = cyc;
          c_req[0] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (nd !== 2) begin
      n_err++;
      $display("FAIL b2b_count: got %0d pulses exp 2", nd);
    end
    n_cmp++;
    if (t1 !== 4 || t2 !== 9) begin
      n_err++;
      $display("FAIL b2b_timing: got %0d %0d exp 4 9", t1, t2);
    end
    n_cmp++;
    if (c_rdata[0] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL b2b_rdata: got %h exp deadbeef", c_rdata[0]);
    end
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_req[i] = 1'b0;
      d_req[i] = 1'b0;
    end
    c_we = 1'b0; d_we = 1'b0;
    c_addr = 32'h0; d_addr = 32'h0; c_wdata = 32'h0; d_wdata = 32'h0;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_core_read();
    test_dma_write();
    test_alternate();
    test_lat();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
